// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: bundles the video client, CPU client and SDRAM controller rd_*/wr_* signals.
// slave modport is the arbiter's view; master modport is the environment (clients + controller).
// Port summary: vid_* (read-only client), cpu_* (read/write client), rd_data/timeout, mem_rd_*, mem_wr_*.
interface sdram_arbiter_if;
    // video client
    logic        vid_req;
    logic [22:0] vid_address;
    logic [8:0]  vid_burst_length;
    logic        vid_ack;
    logic        vid_valid;
    // CPU client
    logic        cpu_req;
    logic        cpu_we;
    logic [22:0] cpu_address;
    logic [8:0]  cpu_burst_length;
    logic [3:0]  cpu_mask;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;
    logic        cpu_valid;
    logic        cpu_done;
    // shared status / read data
    logic [31:0] rd_data;
    logic        timeout;
    // controller read side
    logic        mem_rd_request;
    logic [22:0] mem_rd_address;
    logic [8:0]  mem_rd_burst_length;
    logic        mem_rd_available;
    logic [31:0] mem_rd_data;
    // controller write side
    logic        mem_wr_request;
    logic [22:0] mem_wr_address;
    logic [8:0]  mem_wr_burst_length;
    logic [3:0]  mem_wr_mask;
    logic [31:0] mem_wr_data;
    logic        mem_wr_done;

    modport slave (
        input  vid_req, vid_address, vid_burst_length,
        output vid_ack, vid_valid,
        input  cpu_req, cpu_we, cpu_address, cpu_burst_length, cpu_mask, cpu_wdata,
        output cpu_ack, cpu_valid, cpu_done,
        output rd_data, timeout,
        output mem_rd_request, mem_rd_address, mem_rd_burst_length,
        input  mem_rd_available, mem_rd_data,
        output mem_wr_request, mem_wr_address, mem_wr_burst_length, mem_wr_mask, mem_wr_data,
        input  mem_wr_done
    );

    modport master (
        output vid_req, vid_address, vid_burst_length,
        input  vid_ack, vid_valid,
        output cpu_req, cpu_we, cpu_address, cpu_burst_length, cpu_mask, cpu_wdata,
        input  cpu_ack, cpu_valid, cpu_done,
        input  rd_data, timeout,
        input  mem_rd_request, mem_rd_address, mem_rd_burst_length,
        output mem_rd_available, mem_rd_data,
        input  mem_wr_request, mem_wr_address, mem_wr_burst_length, mem_wr_mask, mem_wr_data,
        output mem_wr_done
    );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller between a video read client and a CPU read/write client.
// Latency: grant (ack + mem request pulse) registered one cycle after arbitration in IDLE; rd_data/valid lag the controller by 1 cycle.
// Backpressure: one operation in flight; clients hold req during busy and the post-completion gap.
// Ports: clk, rst_n (synchronous, active-low) and bus (sdram_arbiter_if.slave) carrying both client
//        handshakes, shared rd_data, sticky timeout, and the controller rd_*/wr_* interface.
module sdram_arbiter #(
    parameter int GAP_CYCLES       = 6,
    parameter int VIDEO_STREAK_MAX = 4,
    parameter int TIMEOUT_CYCLES   = 1023
) (
    input  logic            clk,
    input  logic            rst_n,
    sdram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_BUSY = 2'd1,
        WR_BUSY = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam int GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam int STREAK_W = $clog2(VIDEO_STREAK_MAX + 1);
    localparam int WD_W     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [GAP_W-1:0]    GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(VIDEO_STREAK_MAX);
    localparam logic [WD_W-1:0]     WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);

    state_t              state_q;
    state_t              state_nxt;
    logic [GAP_W-1:0]    gap_cnt_q;
    logic [WD_W-1:0]     wd_cnt_q;
    logic [STREAK_W-1:0] streak_q;
    logic                owner_cpu_q;

    // registered outputs
    logic        vid_ack_q;
    logic        vid_valid_q;
    logic        cpu_ack_q;
    logic        cpu_valid_q;
    logic        cpu_done_q;
    logic [31:0] rd_data_q;
    logic        timeout_q;
    logic        mem_rd_request_q;
    logic [22:0] mem_rd_address_q;
    logic [8:0]  mem_rd_burst_length_q;
    logic        mem_wr_request_q;
    logic [22:0] mem_wr_address_q;
    logic [8:0]  mem_wr_burst_length_q;
    logic [3:0]  mem_wr_mask_q;
    logic [31:0] mem_wr_data_q;

    // decoded events for this cycle
    logic grant_vid;
    logic grant_cpu;
    logic rd_complete;
    logic wr_complete;
    logic wd_expire;
    logic op_end;
    logic avail_q;

    // The registered availability is simply whichever client valid is currently set.
    assign avail_q = vid_valid_q | cpu_valid_q;

    // ------------------------------------------------------------------
    // Event decode: arbitration in IDLE, completion / watchdog in busy states
    // ------------------------------------------------------------------
    always_comb begin
        grant_vid   = 1'b0;
        grant_cpu   = 1'b0;
        rd_complete = 1'b0;
        wr_complete = 1'b0;
        wd_expire   = 1'b0;
        case (state_q)
            IDLE: begin
                // The CPU only overrides a waiting video request once video has
                // used up its streak allowance.
                if (bus.cpu_req && (!bus.vid_req || streak_q == STREAK_MAX)) begin
                    grant_cpu = 1'b1;
                end else if (bus.vid_req) begin
                    grant_vid = 1'b1;
                end
            end
            RD_BUSY: begin
                // End of burst: registered availability is about to fall 1->0.
                rd_complete = avail_q && !bus.mem_rd_available;
                wd_expire   = !rd_complete && (wd_cnt_q == WD_LAST);
            end
            WR_BUSY: begin
                wr_complete = bus.mem_wr_done;
                wd_expire   = !wr_complete && (wd_cnt_q == WD_LAST);
            end
            default: ;
        endcase
    end

    assign op_end = rd_complete | wr_complete | wd_expire;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (grant_cpu) begin
                    state_nxt = bus.cpu_we ? WR_BUSY : RD_BUSY;
                end else if (grant_vid) begin
                    state_nxt = RD_BUSY;
                end
            end
            RD_BUSY, WR_BUSY: begin
                if (op_end) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = GAP;
        endcase
    end

    // ------------------------------------------------------------------
    // State register and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= GAP;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_cnt_q   <= '0;
            wd_cnt_q    <= '0;
            streak_q    <= '0;
            owner_cpu_q <= 1'b0;
        end else begin
            // Gap counter restarts on every entry into GAP.
            if (state_q == GAP && state_nxt == GAP) begin
                gap_cnt_q <= gap_cnt_q + 1'b1;
            end else begin
                gap_cnt_q <= '0;
            end

            // Watchdog runs only while staying in a busy state; zero on entry.
            if ((state_q == RD_BUSY || state_q == WR_BUSY) && state_nxt == state_q) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end else begin
                wd_cnt_q <= '0;
            end

            if (grant_cpu) begin
                streak_q    <= '0;
                owner_cpu_q <= 1'b1;
            end else if (grant_vid) begin
                owner_cpu_q <= 1'b0;
                // Only count video grants that actually made the CPU wait.
                if (bus.cpu_req && streak_q != STREAK_MAX) begin
                    streak_q <= streak_q + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vid_ack_q             <= 1'b0;
            vid_valid_q           <= 1'b0;
            cpu_ack_q             <= 1'b0;
            cpu_valid_q           <= 1'b0;
            cpu_done_q            <= 1'b0;
            rd_data_q             <= '0;
            timeout_q             <= 1'b0;
            mem_rd_request_q      <= 1'b0;
            mem_rd_address_q      <= '0;
            mem_rd_burst_length_q <= '0;
            mem_wr_request_q      <= 1'b0;
            mem_wr_address_q      <= '0;
            mem_wr_burst_length_q <= '0;
            mem_wr_mask_q         <= '0;
            mem_wr_data_q         <= '0;
        end else begin
            vid_ack_q        <= grant_vid;
            cpu_ack_q        <= grant_cpu;
            mem_rd_request_q <= grant_vid | (grant_cpu & ~bus.cpu_we);
            mem_wr_request_q <= grant_cpu & bus.cpu_we;
            cpu_done_q       <= op_end & owner_cpu_q;

            if (wd_expire) begin
                timeout_q <= 1'b1;
            end

            // Command fields are captured only at grant and then held, so the
            // controller sees them stable for the whole operation.
            if (grant_vid) begin
                mem_rd_address_q      <= bus.vid_address;
                mem_rd_burst_length_q <= bus.vid_burst_length;
            end else if (grant_cpu && !bus.cpu_we) begin
                mem_rd_address_q      <= bus.cpu_address;
                mem_rd_burst_length_q <= bus.cpu_burst_length;
            end else if (grant_cpu && bus.cpu_we) begin
                mem_wr_address_q      <= bus.cpu_address;
                mem_wr_burst_length_q <= bus.cpu_burst_length;
                mem_wr_mask_q         <= bus.cpu_mask;
                mem_wr_data_q         <= bus.cpu_wdata;
            end

            if (state_q == RD_BUSY) begin
                rd_data_q <= bus.mem_rd_data;
            end

            // Valid follows the controller only while the read stays in flight.
            if (state_q == RD_BUSY && state_nxt == RD_BUSY) begin
                cpu_valid_q <= owner_cpu_q & bus.mem_rd_available;
                vid_valid_q <= ~owner_cpu_q & bus.mem_rd_available;
            end else begin
                cpu_valid_q <= 1'b0;
                vid_valid_q <= 1'b0;
            end
        end
    end

    assign bus.vid_ack             = vid_ack_q;
    assign bus.vid_valid           = vid_valid_q;
    assign bus.cpu_ack             = cpu_ack_q;
    assign bus.cpu_valid           = cpu_valid_q;
    assign bus.cpu_done            = cpu_done_q;
    assign bus.rd_data             = rd_data_q;
    assign bus.timeout             = timeout_q;
    assign bus.mem_rd_request      = mem_rd_request_q;
    assign bus.mem_rd_address      = mem_rd_address_q;
    assign bus.mem_rd_burst_length = mem_rd_burst_length_q;
    assign bus.mem_wr_request      = mem_wr_request_q;
    assign bus.mem_wr_address      = mem_wr_address_q;
    assign bus.mem_wr_burst_length = mem_wr_burst_length_q;
    assign bus.mem_wr_mask         = mem_wr_mask_q;
    assign bus.mem_wr_data         = mem_wr_data_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed bench for sdram_arbiter with a small SDRAM controller model.
// Read model: data starts 3 cycles after mem_rd_request, one beat per cycle; write model: mem_wr_done 3 cycles after request.
// Expected values are hand-derived cycle counts relative to the grant edge.
module tb_sdram_arbiter;
    localparam int GAP    = 6;
    localparam int STREAK = 4;
    localparam int TMO    = 1023;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sdram_arbiter_if bus();

    sdram_arbiter #(
        .GAP_CYCLES       (GAP),
        .VIDEO_STREAK_MAX (STREAK),
        .TIMEOUT_CYCLES   (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int   total   = 0;
    int   passed  = 0;
    logic overlap = 1'b0;

    // ---------------- controller model (drives on negedge) ----------------
    logic wr_hang = 1'b0;
    int   rd_wait = -1;
    int   rd_left = 0;
    int   rd_idx  = 0;
    int   wr_wait = -1;

    initial begin
        bus.mem_rd_available = 1'b0;
        bus.mem_rd_data      = 32'h0;
        bus.mem_wr_done      = 1'b0;
        forever begin
            @(negedge clk);
            bus.mem_wr_done = 1'b0;
            if (rst_n !== 1'b1) begin
                rd_wait = -1;
                wr_wait = -1;
                bus.mem_rd_available = 1'b0;
            end else begin
                if (bus.mem_rd_request) begin
                    rd_wait = 2;
                    rd_left = int'(bus.mem_rd_burst_length);
                    rd_idx  = 0;
                end else if (rd_wait > 0) begin
                    rd_wait--;
                end else if (rd_wait == 0) begin
                    if (rd_left > 0) begin
                        bus.mem_rd_available = 1'b1;
                        bus.mem_rd_data      = 32'hC0DE_0000 + 32'(rd_idx);
                        rd_idx++;
                        rd_left--;
                    end else begin
                        bus.mem_rd_available = 1'b0;
                        rd_wait = -1;
                    end
                end
                if (bus.mem_wr_request) begin
                    wr_wait = wr_hang ? -1 : 3;
                end else if (wr_wait > 0) begin
                    wr_wait--;
                end
                if (wr_wait == 0) begin
                    bus.mem_wr_done = 1'b1;
                    wr_wait = -1;
                end
            end
        end
    end

    // ---------------- pulse monitors ----------------
    int done_cnt  = 0;
    int rdreq_cnt = 0;
    int vbeat_cnt = 0;
    always @(negedge clk) begin
        if (bus.cpu_done)       done_cnt++;
        if (bus.mem_rd_request) rdreq_cnt++;
        if (bus.vid_valid)      vbeat_cnt++;
    end

    function automatic logic [139:0] all_outs();
        return {bus.vid_ack, bus.vid_valid, bus.cpu_ack, bus.cpu_valid, bus.cpu_done,
                bus.rd_data, bus.timeout,
                bus.mem_rd_request, bus.mem_rd_address, bus.mem_rd_burst_length,
                bus.mem_wr_request, bus.mem_wr_address, bus.mem_wr_burst_length,
                bus.mem_wr_mask, bus.mem_wr_data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int budget, output logic got_vid, output logic got_cpu, output int cycles);
        got_vid = 1'b0;
        got_cpu = 1'b0;
        cycles  = 0;
        while (!got_vid && !got_cpu && cycles < budget) begin
            tick();
            cycles++;
            if (bus.vid_valid && bus.cpu_valid) overlap = 1'b1;
            got_vid = bus.vid_ack;
            got_cpu = bus.cpu_ack;
        end
    endtask

    task automatic wait_done(input int budget, output logic seen, output int cycles);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            tick();
            cycles++;
            if (bus.vid_valid && bus.cpu_valid) overlap = 1'b1;
            seen = bus.cpu_done;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.vid_req = 1'b0; bus.vid_address = '0; bus.vid_burst_length = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_address = '0;
        bus.cpu_burst_length = '0; bus.cpu_mask = '0; bus.cpu_wdata = '0;
        repeat (3) tick();
        total++; if (all_outs() !== 140'h0) $display("FAIL reset_outs: got %h want 0", all_outs()); else passed++;
    endtask

    task automatic test_single_read();
        int   rq0, dn0;
        logic early;
        rq0 = rdreq_cnt; dn0 = done_cnt; early = 1'b0;
        rst_n = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_address = 23'h000404; bus.cpu_burst_length = 9'd1;
        for (int k = 1; k <= GAP + 1; k++) begin
            tick();
            if (k <= GAP && bus.cpu_ack) early = 1'b1;
        end
        total++; if (early !== 1'b0) $display("FAIL t1_ack_early: got %b want 0", early); else passed++;
        total++; if (bus.cpu_ack !== 1'b1) $display("FAIL t1_ack_at_gap: got %b want 1", bus.cpu_ack); else passed++;
        total++; if (bus.mem_rd_request !== 1'b1) $display("FAIL t1_rdreq: got %b want 1", bus.mem_rd_request); else passed++;
        total++; if (bus.mem_rd_address !== 23'h000404) $display("FAIL t1_addr: got %h want 000404", bus.mem_rd_address); else passed++;
        total++; if (bus.mem_rd_burst_length !== 9'd1) $display("FAIL t1_len: got %0d want 1", bus.mem_rd_burst_length); else passed++;
        bus.cpu_req = 1'b0;
        tick();
        total++; if ({bus.cpu_ack, bus.mem_rd_request} !== 2'b00) $display("FAIL t1_pulse_width: got %b want 00", {bus.cpu_ack, bus.mem_rd_request}); else passed++;
        tick(); tick();
        total++; if (bus.cpu_valid !== 1'b0) $display("FAIL t1_valid_pre: got %b want 0", bus.cpu_valid); else passed++;
        tick();
        total++; if (bus.cpu_valid !== 1'b1) $display("FAIL t1_valid: got %b want 1", bus.cpu_valid); else passed++;
        total++; if (bus.rd_data !== 32'hC0DE0000) $display("FAIL t1_rd_data: got %h want c0de0000", bus.rd_data); else passed++;
        total++; if (bus.vid_valid !== 1'b0) $display("FAIL t1_vid_valid: got %b want 0", bus.vid_valid); else passed++;
        tick();
        total++; if ({bus.cpu_valid, bus.cpu_done} !== 2'b01) $display("FAIL t1_done: got %b want 01", {bus.cpu_valid, bus.cpu_done}); else passed++;
        tick();
        total++; if (bus.cpu_done !== 1'b0) $display("FAIL t1_done_width: got %b want 0", bus.cpu_done); else passed++;
        total++; if (bus.mem_rd_address !== 23'h000404) $display("FAIL t1_addr_hold: got %h want 000404", bus.mem_rd_address); else passed++;
        total++; if (rdreq_cnt - rq0 !== 1) $display("FAIL t1_rdreq_count: got %0d want 1", rdreq_cnt - rq0); else passed++;
        total++; if (done_cnt - dn0 !== 1) $display("FAIL t1_done_count: got %0d want 1", done_cnt - dn0); else passed++;
    endtask

    task automatic test_priority();
        logic gv, gc, seen;
        int   cyc, vb0;
        overlap = 1'b0;
        vb0 = vbeat_cnt;
        bus.vid_req = 1'b1; bus.vid_address = 23'h000100; bus.vid_burst_length = 9'd2;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_address = 23'h000200; bus.cpu_burst_length = 9'd1;
        wait_ack(50, gv, gc, cyc);
        bus.vid_req = 1'b0;
        total++; if ({gv, gc} !== 2'b10) $display("FAIL t2_first_grant: got vid/cpu %b want 10", {gv, gc}); else passed++;
        total++; if (cyc !== 6) $display("FAIL t2_gap_wait: got %0d want 6", cyc); else passed++;
        total++; if (bus.mem_rd_address !== 23'h000100) $display("FAIL t2_vid_addr: got %h want 000100", bus.mem_rd_address); else passed++;
        wait_ack(50, gv, gc, cyc);
        bus.cpu_req = 1'b0;
        total++; if ({gv, gc} !== 2'b01) $display("FAIL t2_second_grant: got vid/cpu %b want 01", {gv, gc}); else passed++;
        total++; if (cyc !== 13) $display("FAIL t2_cpu_wait: got %0d want 13", cyc); else passed++;
        total++; if (vbeat_cnt - vb0 !== 2) $display("FAIL t2_vid_beats: got %0d want 2", vbeat_cnt - vb0); else passed++;
        wait_done(50, seen, cyc);
        total++; if (cyc !== 5) $display("FAIL t2_cpu_done: got %0d cycles (seen %b) want 5", cyc, seen); else passed++;
        total++; if (overlap !== 1'b0) $display("FAIL t2_valid_overlap: got %b want 0", overlap); else passed++;
    endtask

    task automatic test_streak();
        logic       gv, gc;
        int         cyc;
        logic [5:0] cpu_pat, any_pat;
        cpu_pat = '0; any_pat = '0;
        bus.vid_req = 1'b1; bus.vid_address = 23'h000300; bus.vid_burst_length = 9'd1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_address = 23'h000400; bus.cpu_burst_length = 9'd1;
        for (int i = 0; i < 6; i++) begin
            wait_ack(100, gv, gc, cyc);
            cpu_pat[i] = gc;
            any_pat[i] = gv | gc;
            if (gc) bus.cpu_req = 1'b0;
        end
        bus.vid_req = 1'b0;
        total++; if (any_pat !== 6'b111111) $display("FAIL t3_grants: got %b want 111111", any_pat); else passed++;
        total++; if (cpu_pat !== 6'b010000) $display("FAIL t3_order: got %b want 010000", cpu_pat); else passed++;
        repeat (20) tick();
    endtask

    task automatic test_write();
        logic gv, gc, stable, early;
        int   cyc;
        stable = 1'b1; early = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_address = 23'h001234;
        bus.cpu_burst_length = 9'd8; bus.cpu_mask = 4'b0011; bus.cpu_wdata = 32'hDEADBEEF;
        wait_ack(100, gv, gc, cyc);
        total++; if (gc !== 1'b1) $display("FAIL t4_ack: got %b want 1", gc); else passed++;
        total++; if ({bus.mem_wr_request, bus.mem_rd_request} !== 2'b10) $display("FAIL t4_req: got wr/rd %b want 10", {bus.mem_wr_request, bus.mem_rd_request}); else passed++;
        total++; if (bus.mem_wr_address !== 23'h001234) $display("FAIL t4_addr: got %h want 001234", bus.mem_wr_address); else passed++;
        total++; if (bus.mem_wr_burst_length !== 9'd8) $display("FAIL t4_len: got %0d want 8", bus.mem_wr_burst_length); else passed++;
        bus.cpu_req = 1'b0; bus.cpu_wdata = 32'h0; bus.cpu_mask = 4'hF;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (bus.mem_wr_mask !== 4'b0011 || bus.mem_wr_data !== 32'hDEADBEEF) stable = 1'b0;
            if (bus.cpu_done) early = 1'b1;
        end
        total++; if (stable !== 1'b1) $display("FAIL t4_stable: got %b want 1", stable); else passed++;
        total++; if (early !== 1'b0) $display("FAIL t4_done_early: got %b want 0", early); else passed++;
        tick();
        total++; if (bus.cpu_done !== 1'b1) $display("FAIL t4_done: got %b want 1", bus.cpu_done); else passed++;
        total++; if ({bus.mem_wr_mask, bus.mem_wr_data} !== {4'b0011, 32'hDEADBEEF}) $display("FAIL t4_hold: got %h want 3deadbeef", {bus.mem_wr_mask, bus.mem_wr_data}); else passed++;
        tick();
        total++; if (bus.cpu_done !== 1'b0) $display("FAIL t4_done_width: got %b want 0", bus.cpu_done); else passed++;
    endtask

    task automatic test_zero_length();
        logic gv, gc, seen;
        int   cyc;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_address = 23'h7FFFFF;
        bus.cpu_burst_length = 9'd0; bus.cpu_mask = 4'hF; bus.cpu_wdata = 32'h12345678;
        wait_ack(100, gv, gc, cyc);
        bus.cpu_req = 1'b0;
        total++; if (bus.mem_wr_burst_length !== 9'd0) $display("FAIL zl_len: got %0d want 0", bus.mem_wr_burst_length); else passed++;
        total++; if (bus.mem_wr_address !== 23'h7FFFFF) $display("FAIL zl_addr: got %h want 7fffff", bus.mem_wr_address); else passed++;
        wait_done(50, seen, cyc);
        total++; if (seen !== 1'b1) $display("FAIL zl_done: got %b want 1", seen); else passed++;
    endtask

    task automatic test_timeout();
        logic gv, gc, early;
        int   cyc;
        early = 1'b0;
        wr_hang = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_address = 23'h002000;
        bus.cpu_burst_length = 9'd4; bus.cpu_mask = 4'hF; bus.cpu_wdata = 32'hA5A5A5A5;
        wait_ack(100, gv, gc, cyc);
        bus.cpu_req = 1'b0;
        bus.vid_req = 1'b1; bus.vid_address = 23'h000555; bus.vid_burst_length = 9'd1;
        total++; if (gc !== 1'b1) $display("FAIL t5_ack: got %b want 1", gc); else passed++;
        for (int k = 1; k < TMO; k++) begin
            tick();
            if (bus.timeout || bus.cpu_done || bus.vid_ack) early = 1'b1;
        end
        total++; if (early !== 1'b0) $display("FAIL t5_early: got %b want 0", early); else passed++;
        tick();
        total++; if ({bus.timeout, bus.cpu_done} !== 2'b11) $display("FAIL t5_expire: got timeout/done %b want 11", {bus.timeout, bus.cpu_done}); else passed++;
        wr_hang = 1'b0;
        wait_ack(50, gv, gc, cyc);
        bus.vid_req = 1'b0;
        total++; if ({gv, gc} !== 2'b10) $display("FAIL t5_vid_served: got vid/cpu %b want 10", {gv, gc}); else passed++;
        total++; if (cyc !== GAP + 1) $display("FAIL t5_vid_wait: got %0d want %0d", cyc, GAP + 1); else passed++;
        repeat (15) tick();
        total++; if (bus.timeout !== 1'b1) $display("FAIL t5_sticky: got %b want 1", bus.timeout); else passed++;
    endtask

    task automatic test_reset_mid_op();
        logic gv, gc, seen;
        int   cyc, dn0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_address = 23'h000ABC; bus.cpu_burst_length = 9'd4;
        wait_ack(100, gv, gc, cyc);
        bus.cpu_req = 1'b0;
        repeat (4) tick();
        total++; if (bus.cpu_valid !== 1'b1) $display("FAIL t6_busy: got %b want 1", bus.cpu_valid); else passed++;
        dn0 = done_cnt;
        rst_n = 1'b0;
        tick();
        total++; if (all_outs() !== 140'h0) $display("FAIL t6_outs_zero: got %h want 0", all_outs()); else passed++;
        tick();
        rst_n = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_address = 23'h000DEF; bus.cpu_burst_length = 9'd1;
        wait_ack(50, gv, gc, cyc);
        bus.cpu_req = 1'b0;
        total++; if ({gv, gc} !== 2'b01) $display("FAIL t6_regrant: got vid/cpu %b want 01", {gv, gc}); else passed++;
        total++; if (cyc !== GAP + 1) $display("FAIL t6_gap_after_reset: got %0d want %0d", cyc, GAP + 1); else passed++;
        total++; if (bus.mem_rd_address !== 23'h000DEF) $display("FAIL t6_addr: got %h want 000def", bus.mem_rd_address); else passed++;
        wait_done(50, seen, cyc);
        tick();
        total++; if (done_cnt - dn0 !== 1) $display("FAIL t6_done_count: got %0d want 1", done_cnt - dn0); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_streak();
        test_write();
        test_zero_length();
        test_timeout();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
